universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised successor to the controlled buffer register.
- Adds the following to the plain load/hold behaviour:
  - single-step shift left/right with serial fill;
  - rotate left/right;
  - a multi-cycle "shift by N" operation with busy/done status.
- Serves as the general-purpose data-holding and serialising register for datapath and serial-interface blocks.
- Single clock domain; no internal pipelining beyond the state register.

Parameters:
- buff_len, 8, register width in bits (>= 2).
- amt_w, 4, width of the shift-amount input. Must satisfy 2**amt_w > buff_len.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- mode  input  3  operation select, decoded only when idle (see Behaviour).
- x  input  buff_len  parallel load data.
- amt  input  amt_w  shift count for multi-shift modes, sampled at command acceptance.
- sin_msb  input  1  serial bit entering q[buff_len-1] on right shifts.
- sin_lsb  input  1  serial bit entering q[0] on left shifts.
- q  output  buff_len  register contents.
- sout_r  output  1  q[0], combinational from q.
- sout_l  output  1  q[buff_len-1], combinational from q.
- busy  output  1  high while a multi-shift is in progress.
- done  output  1  one-cycle pulse when a multi-shift completes.

Behaviour:
- Reset: clr=1 at a rising edge forces the following, overriding every other input:
  - q=0, busy=0, done=0;
  - internal counter=0, FSM=IDLE.
  - A reset during BUSY aborts the operation; no done pulse follows.
- FSM states: IDLE, BUSY.
- IDLE: mode is decoded at each edge.
  - 000 hold: q unchanged.
  - 001 load: q<=x.
  - 010 shift right: q<={sin_msb, q[buff_len-1:1]}.
  - 011 shift left: q<={q[buff_len-2:0], sin_lsb}.
  - 100 rotate right: q<={q[0], q[buff_len-1:1]}.
  - 101 rotate left: q<={q[buff_len-2:0], q[buff_len-1]}.
  - 110 multi-shift right by amt; 111 multi-shift left by amt:
    - On the accepting edge, direction is latched, cnt<=amt, and q is unchanged.
    - If amt!=0: go to BUSY and set busy<=1.
    - If amt==0: stay IDLE and set done<=1 for one cycle.
- BUSY: mode, x and amt are ignored.
  - Each edge performs one shift in the latched direction and decrements cnt.
  - The fill bit is sin_msb (right) or sin_lsb (left), sampled at that edge.
  - At the edge where cnt==1 (the final shift), set busy<=0 and done<=1, and return to IDLE.
- Timing:
  - busy is high for exactly amt cycles.
  - done is high for exactly one cycle, starting amt+1 edges after acceptance.
  - The final q is valid in that same cycle.
- amt greater than buff_len is legal: the register shifts amt times and all bits come from the serial input.
- done is 0 in every cycle except the completion cycle.
- While done=1 the FSM is IDLE, so a new command (any mode) is accepted at that edge. Back-to-back multi-shifts are therefore allowed.
- Single-step modes complete in one edge and never assert busy or done.
- sout_r and sout_l follow q combinationally. Because q is 0 after reset, both are 0 after reset.

Test Plan:
- Reset/load:
  - clr=1 for 2 edges -> q=0x00, busy=0, done=0.
  - Then mode=001, x=0xA5 -> q=0xA5 after 1 edge; sout_l=1, sout_r=1.
  - Then mode=000 for 3 edges -> q stays 0xA5.
- Single-step shifts and rotates, starting from q=0xA5:
  - mode=010, sin_msb=0 -> q=0x52.
  - mode=011, sin_lsb=1 -> q=0xA5.
  - mode=100 -> q=0xD2.
  - mode=101 -> q=0xA5.
- Multi-shift left:
  - From q=0x81: mode=111, amt=3, sin_lsb=1 held.
  - -> busy=1 for 3 cycles, mode toggling during busy is ignored.
  - -> done pulses 1 cycle at acceptance+4 with q=0x0F; busy=0 in the done cycle.
- amt edge cases:
  - amt=0 with mode=110 -> done=1 the next cycle, busy never asserts, q unchanged.
  - amt=10 right from q=0xFF with sin_msb=0 -> busy 10 cycles, done, q=0x00.
- Reset mid-operation:
  - Start mode=110, amt=6 from q=0xF0.
  - Assert clr on the 3rd busy cycle -> q=0x00, busy=0, and no done pulse in the following 10 cycles.
- Back-to-back:
  - In the done cycle of a multi-shift, apply mode=001, x=0x3C -> q=0x3C at the next edge.
  - Then mode=110, amt=2 immediately -> busy 2 cycles, then done with q=0x0F (sin_msb=0).

Source files
------------

// File: rtl/universal_shift_reg.sv
// ============================================================================
//  Module      : universal_shift_reg
//  Description : Parametrised load/hold/shift/rotate register with a
//                multi-cycle "shift by N" operation and busy/done status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg #(
    parameter int buff_len = 8,
    parameter int amt_w    = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [2:0]          mode,
    input  logic [buff_len-1:0] x,
    input  logic [amt_w-1:0]    amt,
    input  logic                sin_msb,
    input  logic                sin_lsb,
    output logic [buff_len-1:0] q,
    output logic                sout_r,
    output logic                sout_l,
    output logic                busy,
    output logic                done
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_LOAD = 3'b001;
    localparam logic [2:0] c_SHR  = 3'b010;
    localparam logic [2:0] c_SHL  = 3'b011;
    localparam logic [2:0] c_ROR  = 3'b100;
    localparam logic [2:0] c_ROL  = 3'b101;
    localparam logic [2:0] c_MSR  = 3'b110;
    localparam logic [2:0] c_MSL  = 3'b111;

    localparam logic [amt_w-1:0] c_CNT_ONE  = amt_w'(1);
    localparam logic [amt_w-1:0] c_CNT_ZERO = '0;

    logic [0:0]          r_state, w_state_nxt;
    logic [buff_len-1:0] r_q, w_q_nxt;
    logic [amt_w-1:0]    r_cnt, w_cnt_nxt;
    logic                r_dir, w_dir_nxt;     // 1 = left
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (mode[2:1] == 2'b11 && amt != c_CNT_ZERO) w_state_nxt = c_BUSY;
            c_BUSY: if (r_cnt == c_CNT_ONE) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        if (r_state == c_BUSY) begin
            // mode, x and amt are ignored until the count runs out
            w_q_nxt   = r_dir ? {r_q[buff_len-2:0], sin_lsb} : {sin_msb, r_q[buff_len-1:1]};
            w_cnt_nxt = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
        end else begin
            case (mode)
                c_HOLD: w_q_nxt = r_q;
                c_LOAD: w_q_nxt = x;
                c_SHR:  w_q_nxt = {sin_msb, r_q[buff_len-1:1]};
                c_SHL:  w_q_nxt = {r_q[buff_len-2:0], sin_lsb};
                c_ROR:  w_q_nxt = {r_q[0], r_q[buff_len-1:1]};
                c_ROL:  w_q_nxt = {r_q[buff_len-2:0], r_q[buff_len-1]};
                c_MSR, c_MSL: begin
                    w_dir_nxt = mode[0];
                    w_cnt_nxt = amt;
                    if (amt == c_CNT_ZERO) w_done_nxt = 1'b1;
                    else                   w_busy_nxt = 1'b1;
                end
                default: w_q_nxt = r_q;
            endcase
        end
    end

    assign q      = r_q;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sout_r = r_q[0];
    assign sout_l = r_q[buff_len-1];

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
//  Module      : tb_universal_shift_reg
//  Description : Directed plus random checks of universal_shift_reg against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  x = '0;
    logic [AW-1:0] amt = '0;
    logic          sin_msb = 1'b0;
    logic          sin_lsb = 1'b0;
    logic [W-1:0]  q;
    logic          sout_r, sout_l, busy, done;

    int tests = 0;
    int fails = 0;

    // reference model: register value, shifts still owed, direction, done flag
    logic [W-1:0] mq = '0;
    int           mrem = 0;
    logic         mleft = 1'b0;
    logic         mdone = 1'b0;

    universal_shift_reg #(.buff_len(W), .amt_w(AW)) dut (
        .clk(clk), .clr(clr), .mode(mode), .x(x), .amt(amt),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c, input logic [2:0] m, input logic [W-1:0] xv,
                        input logic [AW-1:0] a, input logic sm, input logic sl);
        @(negedge clk);
        clr = c; mode = m; x = xv; amt = a; sin_msb = sm; sin_lsb = sl;
        @(posedge clk);
        if (c) begin
            mq = '0; mrem = 0; mdone = 1'b0;
        end else if (mrem > 0) begin
            mq    = mleft ? ((mq << 1) | W'(sl)) : ((mq >> 1) | (W'(sm) << (W-1)));
            mrem  = mrem - 1;
            mdone = (mrem == 0);
        end else begin
            mdone = 1'b0;
            case (m)
                3'd1: mq = xv;
                3'd2: mq = (mq >> 1) | (W'(sm) << (W-1));
                3'd3: mq = (mq << 1) | W'(sl);
                3'd4: mq = (mq >> 1) | (mq << (W-1));
                3'd5: mq = (mq << 1) | (mq >> (W-1));
                3'd6, 3'd7: begin
                    mleft = m[0];
                    mrem  = int'(a);
                    mdone = (a == '0);
                end
                default: ;
            endcase
        end
        #1;
        chk("q", 32'(q), 32'(mq));
        chk("busy", 32'(busy), 32'(mrem > 0));
        chk("done", 32'(done), 32'(mdone));
        chk("sout_r", 32'(sout_r), 32'(mq[0]));
        chk("sout_l", 32'(sout_l), 32'(mq[W-1]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and load
        step(1, 3'd0, 8'h00, 4'd0, 0, 0);
        step(1, 3'd0, 8'h00, 4'd0, 0, 0);
        chk("reset_q", 32'(q), 32'h00);
        step(0, 3'd1, 8'hA5, 4'd0, 0, 0);
        chk("load_q", 32'(q), 32'hA5);
        repeat (3) step(0, 3'd0, 8'h5A, 4'd0, 1, 1);
        chk("hold_q", 32'(q), 32'hA5);

        // single-step shifts and rotates
        step(0, 3'd2, 8'h00, 4'd0, 0, 0); chk("shr_q", 32'(q), 32'h52);
        step(0, 3'd3, 8'h00, 4'd0, 0, 1); chk("shl_q", 32'(q), 32'hA5);
        step(0, 3'd4, 8'h00, 4'd0, 0, 0); chk("ror_q", 32'(q), 32'hD2);
        step(0, 3'd5, 8'h00, 4'd0, 0, 0); chk("rol_q", 32'(q), 32'hA5);

        // multi-shift left by 3, mode toggling while busy
        step(0, 3'd1, 8'h81, 4'd0, 0, 1);
        step(0, 3'd7, 8'h00, 4'd3, 0, 1);
        step(0, 3'd1, 8'hFF, 4'd9, 0, 1);
        step(0, 3'd6, 8'h00, 4'd1, 0, 1);
        step(0, 3'd2, 8'h00, 4'd0, 0, 1);
        chk("msl_q", 32'(q), 32'h0F);
        chk("msl_done", 32'(done), 32'h1);

        // amt = 0 and amt > width
        step(0, 3'd6, 8'h00, 4'd0, 1, 1);
        chk("amt0_done", 32'(done), 32'h1);
        chk("amt0_busy", 32'(busy), 32'h0);
        step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        step(0, 3'd1, 8'hFF, 4'd0, 0, 0);
        step(0, 3'd6, 8'h00, 4'd10, 0, 0);
        repeat (10) step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        chk("amt10_q", 32'(q), 32'h00);
        chk("amt10_done", 32'(done), 32'h1);

        // reset during a multi-shift aborts it without a done pulse
        step(0, 3'd1, 8'hF0, 4'd0, 0, 0);
        step(0, 3'd6, 8'h00, 4'd6, 0, 0);
        step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        step(1, 3'd0, 8'h00, 4'd0, 0, 0);
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (10) step(0, 3'd0, 8'h00, 4'd0, 0, 0);

        // back-to-back commands from the done cycle
        step(0, 3'd1, 8'hF0, 4'd0, 0, 0);
        step(0, 3'd7, 8'h00, 4'd1, 0, 0);
        step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        chk("b2b_done", 32'(done), 32'h1);
        step(0, 3'd1, 8'h3C, 4'd0, 0, 0);
        chk("b2b_load", 32'(q), 32'h3C);
        step(0, 3'd6, 8'h00, 4'd2, 0, 0);
        step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        step(0, 3'd0, 8'h00, 4'd0, 0, 0);
        chk("b2b_q", 32'(q), 32'h0F);
        chk("b2b_done2", 32'(done), 32'h1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 3'($urandom), 8'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
